// File: rtl/data_mem_ctrl_pkg.sv
// Shared definitions for the data memory controller: MIPS load/store
// opcodes, FSM state encoding and the alignment rule.
package data_mem_ctrl_pkg;

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  // Halfwords need an even address, words a 4-byte aligned one.
  function automatic logic is_misaligned(input logic [5:0] op, input logic [1:0] a);
    case (op)
      OP_LH, OP_LHU, OP_SH: return a[0];
      OP_LW, OP_SW:         return (a != 2'b00);
      default:              return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-wide data array with per-byte write enables and a registered read port.
module dmem_array #(
  parameter int DEPTH_WORDS = 1024,
  parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic             clk,
  input  logic [3:0]       wr_be,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [31:0]      wr_data,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [31:0]      rd_data
);

  logic [31:0] mem [DEPTH_WORDS];

  // Byte-enabled write; lanes with a clear enable keep their old contents.
  always_ff @(posedge clk) begin
    for (int n = 0; n < 4; n++) begin
      if (wr_be[n]) mem[wr_idx][8*n +: 8] <= wr_data[8*n +: 8];
    end
  end

  // Read data appears the cycle after the index is presented.
  always_ff @(posedge clk) begin
    rd_data <= mem[rd_idx];
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// Load/store unit front end: accepts one MIPS memory op at a time, inserts
// WAIT_CYCLES wait states, accesses the array and returns extended data.
module data_mem_ctrl
  import data_mem_ctrl_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [5:0]  req_opcode,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        busy
);

  localparam int         IDX_W     = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [5:0]  op_q, op_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic             mis;
  logic [3:0]       wr_be;
  logic [31:0]      wr_data;
  logic [IDX_W-1:0] rd_idx;
  logic [31:0]      rd_word;
  logic [7:0]       rd_byte;
  logic [15:0]      rd_half;
  logic [31:0]      ld_data;

  // The array read is registered, so while idle it is pointed at the incoming
  // address; the word is then ready by ACCESS even with zero wait states.
  assign rd_idx = (state_q == ST_IDLE) ? req_addr[IDX_W+1:2] : addr_q[IDX_W+1:2];

  dmem_array #(.DEPTH_WORDS(DEPTH_WORDS), .IDX_W(IDX_W)) u_array (
    .clk     (clk),
    .wr_be   (wr_be),
    .wr_idx  (addr_q[IDX_W+1:2]),
    .wr_data (wr_data),
    .rd_idx  (rd_idx),
    .rd_data (rd_word)
  );

  assign mis     = is_misaligned(op_q, addr_q[1:0]);
  assign rd_byte = rd_word[8*addr_q[1:0] +: 8];
  assign rd_half = addr_q[1] ? rd_word[31:16] : rd_word[15:0];

  // Lane selection and extension of load data; stores and unknown ops give 0.
  always_comb begin
    ld_data = '0;
    case (op_q)
      OP_LB:   ld_data = {{24{rd_byte[7]}}, rd_byte};
      OP_LBU:  ld_data = {24'd0, rd_byte};
      OP_LH:   ld_data = {{16{rd_half[15]}}, rd_half};
      OP_LHU:  ld_data = {16'd0, rd_half};
      OP_LW:   ld_data = rd_word;
      default: ld_data = '0;
    endcase
  end

  // Store lane enables; reset in the ACCESS cycle suppresses the write.
  always_comb begin
    wr_be   = 4'b0000;
    wr_data = wdata_q;
    case (op_q)
      OP_SB: begin
        wr_be   = 4'b0001 << addr_q[1:0];
        wr_data = {4{wdata_q[7:0]}};
      end
      OP_SH: begin
        wr_be   = addr_q[1] ? 4'b1100 : 4'b0011;
        wr_data = {2{wdata_q[15:0]}};
      end
      OP_SW:   wr_be = 4'b1111;
      default: wr_be = 4'b0000;
    endcase
    if (state_q != ST_ACCESS || mis || rst) wr_be = 4'b0000;
  end

  // Next-state and handshake logic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    req_ready = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          op_d    = req_opcode;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          if (WAIT_CYCLES > 0) begin
            state_d = ST_WAIT;
            cnt_d   = WAIT_LOAD;
          end else begin
            state_d = ST_ACCESS;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) state_d = ST_ACCESS;
        else               cnt_d   = cnt_q - 4'd1;
      end
      ST_ACCESS: begin
        state_d = ST_RESP;
        err_d   = mis;
        rdata_d = mis ? 32'd0 : ld_data;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and captured-request registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign resp_valid = (state_q == ST_RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl with WAIT_CYCLES=2.
module tb_data_mem_ctrl;

  localparam logic [5:0] LB = 6'h20, LH = 6'h21, LW = 6'h23, LBU = 6'h24,
                         LHU = 6'h25, SB = 6'h28, SH = 6'h29, SW = 6'h2B;
  localparam int EXP_LAT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [5:0]  req_opcode;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [5:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  vec_t vq[$];

  data_mem_ctrl #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_opcode (req_opcode),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Present a request at a negedge; returns at the negedge of the cycle after accept.
  task automatic accept(input logic [5:0] op, input logic [31:0] a, input logic [31:0] wd);
    @(negedge clk);
    req_valid = 1'b1; req_opcode = op; req_addr = a; req_wdata = wd;
    chk("accept_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    chk("busy_after_accept", 32'(busy), 32'd1);
    chk("ready_low_after_accept", 32'(req_ready), 32'd0);
  endtask

  // Called at the negedge one cycle after accept; lat counts cycles from accept.
  task automatic wait_resp(output logic [31:0] rd, output logic er, output int lat);
    lat = 1;
    while (!resp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    rd = resp_rdata;
    er = resp_err;
    @(negedge clk);
    chk("resp_single_pulse", 32'(resp_valid), 32'd0);
    chk("resp_rdata_hold", resp_rdata, rd);
  endtask

  task automatic run_vec(input int i, input vec_t v);
    logic [31:0] rd;
    logic        er;
    int          lat;
    accept(v.op, v.addr, v.wdata);
    wait_resp(rd, er, lat);
    chk($sformatf("v%0d_latency", i), 32'(lat), 32'(EXP_LAT));
    chk($sformatf("v%0d_rdata", i), rd, v.rdata);
    chk($sformatf("v%0d_err", i), 32'(er), 32'(v.err));
  endtask

  task automatic watch_no_resp(input string nm, input int cycles);
    int seen = 0;
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      if (resp_valid) seen++;
    end
    chk(nm, 32'(seen), 32'd0);
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          n;

    vq.push_back('{SW,  32'h10,   32'hDEADBEEF, 32'h00000000, 1'b0});
    vq.push_back('{LW,  32'h10,   32'h0,        32'hDEADBEEF, 1'b0});
    vq.push_back('{SB,  32'h13,   32'h000000A5, 32'h00000000, 1'b0});
    vq.push_back('{LW,  32'h10,   32'h0,        32'hA5ADBEEF, 1'b0});
    vq.push_back('{LB,  32'h13,   32'h0,        32'hFFFFFFA5, 1'b0});
    vq.push_back('{LBU, 32'h13,   32'h0,        32'h000000A5, 1'b0});
    vq.push_back('{SH,  32'h16,   32'h00001234, 32'h00000000, 1'b0});
    vq.push_back('{LHU, 32'h16,   32'h0,        32'h00001234, 1'b0});
    vq.push_back('{LH,  32'h10,   32'h0,        32'hFFFFBEEF, 1'b0});
    vq.push_back('{LW,  32'h11,   32'h0,        32'h00000000, 1'b1});
    vq.push_back('{SW,  32'h22,   32'hFFFFFFFF, 32'h00000000, 1'b1});
    vq.push_back('{LW,  32'h20,   32'h0,        32'h00000000, 1'b0});
    vq.push_back('{LW,  32'h14,   32'h0,        32'h12340000, 1'b0});
    vq.push_back('{LH,  32'h12,   32'h0,        32'hFFFFA5AD, 1'b0});
    vq.push_back('{LB,  32'h10,   32'h0,        32'hFFFFFFEF, 1'b0});
    vq.push_back('{LBU, 32'h11,   32'h0,        32'h000000BE, 1'b0});
    vq.push_back('{LW,  32'h1010, 32'h0,        32'hA5ADBEEF, 1'b0});
    vq.push_back('{LHU, 32'h13,   32'h0,        32'h00000000, 1'b1});
    vq.push_back('{SH,  32'h11,   32'h0000FFFF, 32'h00000000, 1'b1});
    vq.push_back('{LW,  32'h10,   32'h0,        32'hA5ADBEEF, 1'b0});
    vq.push_back('{6'h3F, 32'h10, 32'hFFFFFFFF, 32'h00000000, 1'b0});
    vq.push_back('{SB,  32'h15,   32'hFFFFFF77, 32'h00000000, 1'b0});
    vq.push_back('{LW,  32'h14,   32'h0,        32'h12347700, 1'b0});
    vq.push_back('{LH,  32'h14,   32'h0,        32'h00007700, 1'b0});

    rst = 1'b1; req_valid = 1'b0; req_opcode = '0; req_addr = '0; req_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_ready",      32'(req_ready),  32'd1);
    chk("rst_busy",       32'(busy),       32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_rdata",      resp_rdata,      32'd0);
    chk("rst_err",        32'(resp_err),   32'd0);

    foreach (vq[i]) run_vec(i, vq[i]);

    // Reset during WAIT: store abandoned, no response, ready right after.
    accept(SW, 32'h30, 32'h11111111);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstwait_ready", 32'(req_ready), 32'd1);
    chk("rstwait_busy",  32'(busy),      32'd0);
    chk("rstwait_rdata", resp_rdata,     32'd0);
    watch_no_resp("rstwait_no_resp", 8);
    run_vec(100, '{LW, 32'h30, 32'h0, 32'h00000000, 1'b0});

    // Reset in the ACCESS cycle must suppress the write.
    accept(SW, 32'h34, 32'h22222222);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstacc_ready", 32'(req_ready), 32'd1);
    watch_no_resp("rstacc_no_resp", 8);
    run_vec(101, '{LW, 32'h34, 32'h0, 32'h00000000, 1'b0});

    // req_valid held: second request accepted the cycle after the first response.
    @(negedge clk);
    req_valid = 1'b1; req_opcode = LW; req_addr = 32'h10; req_wdata = '0;
    chk("b2b_first_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_opcode = 6'h00; req_addr = 32'h40; req_wdata = 32'hFFFFFFFF;
    n = 1;
    while (!resp_valid && n < 20) begin
      chk("b2b_ready_low", 32'(req_ready), 32'd0);
      chk("b2b_busy_high", 32'(busy),      32'd1);
      @(negedge clk);
      n++;
    end
    chk("b2b_first_latency", 32'(n), 32'(EXP_LAT));
    chk("b2b_first_rdata",   resp_rdata, 32'hA5ADBEEF);
    chk("b2b_resp_ready",    32'(req_ready), 32'd0);
    @(negedge clk);
    chk("b2b_second_ready", 32'(req_ready),  32'd1);
    chk("b2b_gap_valid",    32'(resp_valid), 32'd0);
    @(negedge clk);
    req_valid = 1'b0;
    chk("b2b_second_busy", 32'(busy), 32'd1);
    wait_resp(rd, er, lat);
    chk("b2b_second_latency", 32'(lat), 32'(EXP_LAT));
    chk("b2b_second_rdata",   rd,       32'd0);
    chk("b2b_second_err",     32'(er),  32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
